// File: rtl/adder_host_driver.sv
// adder_host_driver
//
// Host-side driver for the registered 32-bit adder top. Operand requests
// arrive on a valid/ready port and are issued to the adder pads. A tag
// pipeline follows each operation through the adder's fixed latency, and
// the adder outputs are captured into a result FIFO. Results come back in
// issue order on a second valid/ready port. A credit counter stops
// accepting requests once every FIFO slot is spoken for, so results
// coming out of the adder always have somewhere to go.
//
// Parameters:
//   LATENCY   - edges from a pad update to the matching sum_pad result (>= 1)
//   RSP_DEPTH - result FIFO entries and total credits (power of two, >= 2)
//   TAG_W     - width of the opaque request/response tag
//
// Ports:
//   clk, rst                     - single clock, synchronous active-high reset
//   req_valid/req_ready          - request handshake
//   req_a, req_b, req_cin        - operands and carry in
//   req_tag                      - tag returned with the result
//   a_pad, b_pad, carry_in_pad   - registered drive into the adder top
//   sum_pad, carry_out_pad,
//   overflow_pad                 - adder top results
//   rsp_valid/rsp_ready          - response handshake
//   rsp_sum, rsp_cout, rsp_ovf,
//   rsp_tag                      - result fields at the FIFO head
//   busy                         - operations in flight or results buffered
//   err                          - sticky, FIFO pushed while full

module adder_host_driver #(
  parameter int LATENCY   = 3,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic             req_cin,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      a_pad,
  output logic [31:0]      b_pad,
  output logic             carry_in_pad,
  input  logic [31:0]      sum_pad,
  input  logic             carry_out_pad,
  input  logic             overflow_pad,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic             err
);

  localparam int PTR_W   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 32 + 1 + 1 + TAG_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  logic                 accept;
  logic                 pop;
  logic                 push;
  logic                 fifo_full;
  logic                 do_push;
  logic                 push_overflow;

  logic [LATENCY:0]     pipe_valid;
  logic [TAG_W-1:0]     pipe_tag [LATENCY+1];

  logic [CNT_W-1:0]     used;

  logic [ENTRY_W-1:0]   fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [ENTRY_W-1:0]   head_entry;
  logic [ENTRY_W-1:0]   push_entry;

  // Handshakes. req_ready comes only from the credit register, so there
  // is no combinational path from req_valid or from the response side.
  assign req_ready = (used < DEPTH_C);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = (used != '0);

  // The last tracking stage lines up with the cycle in which sum_pad holds
  // that operation's result, so the capture happens on the following edge.
  assign push          = pipe_valid[LATENCY];
  assign fifo_full     = (count == DEPTH_C);
  assign do_push       = push && (!fifo_full || pop);
  assign push_overflow = push && fifo_full && !pop;
  assign push_entry    = {sum_pad, carry_out_pad, overflow_pad, pipe_tag[LATENCY]};

  assign head_entry = fifo_mem[rd_ptr];
  assign {rsp_sum, rsp_cout, rsp_ovf, rsp_tag} = head_entry;

  // Pad registers only change on an accepted request; holding them
  // otherwise keeps the adder inputs quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_pad        <= '0;
      b_pad        <= '0;
      carry_in_pad <= 1'b0;
    end else if (accept) begin
      a_pad        <= req_a;
      b_pad        <= req_b;
      carry_in_pad <= req_cin;
    end
  end

  // Valid bits of the tracking pipeline. The adder cannot stall, so this
  // shifts every cycle. Clearing it on reset is what discards results of
  // operations that were in flight when reset hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid <= {pipe_valid[LATENCY-1:0], accept};
    end
  end

  // Tags travel alongside the valid bits. They only matter where the
  // matching valid bit is set, so they need no reset.
  always_ff @(posedge clk) begin
    pipe_tag[0] <= req_tag;
    for (int i = 1; i <= LATENCY; i++) begin
      pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  // Credit counter. A credit is taken on accept and returned when the
  // consumer pops the result, so a credit covers an operation's whole life
  // from issue to FIFO exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      used <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   used <= used + CNT_W'(1);
        2'b01:   used <= used - CNT_W'(1);
        default: used <= used;
      endcase
    end
  end

  // FIFO storage. Entries are only meaningful while counted, so the array
  // is not reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  // FIFO pointers and occupancy. The depth is a power of two, so the
  // pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error. The credit scheme should make this unreachable. The
  // push that caused it is dropped rather than overwriting the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (push_overflow) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_host_driver.sv
// tb_adder_host_driver
//
// Drives adder_host_driver with directed requests and provides a
// behavioural registered adder behind the pads. Expected results go into
// a queue when a request is accepted, and a monitor compares each popped
// response against the head of that queue.

module tb_adder_host_driver;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_a;
  logic [31:0]   req_b;
  logic          req_cin;
  logic [TW-1:0] req_tag;
  logic [31:0]   a_pad;
  logic [31:0]   b_pad;
  logic          carry_in_pad;
  logic [31:0]   sum_pad;
  logic          carry_out_pad;
  logic          overflow_pad;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_sum;
  logic          rsp_cout;
  logic          rsp_ovf;
  logic [TW-1:0] rsp_tag;
  logic          busy;
  logic          err;

  typedef struct packed {
    logic [31:0]   sum;
    logic          cout;
    logic          ovf;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;

  int checkCount = 0;
  int passCount  = 0;
  int rspCount   = 0;

  adder_host_driver #(
    .LATENCY  (LAT),
    .RSP_DEPTH(DEPTH),
    .TAG_W    (TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_cin      (req_cin),
    .req_tag      (req_tag),
    .a_pad        (a_pad),
    .b_pad        (b_pad),
    .carry_in_pad (carry_in_pad),
    .sum_pad      (sum_pad),
    .carry_out_pad(carry_out_pad),
    .overflow_pad (overflow_pad),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_sum      (rsp_sum),
    .rsp_cout     (rsp_cout),
    .rsp_ovf      (rsp_ovf),
    .rsp_tag      (rsp_tag),
    .busy         (busy),
    .err          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference 32-bit add: {sum, carry out, signed overflow}.
  function automatic logic [33:0] addModel(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        c);
    logic [32:0] t;
    logic        v;
    t = {1'b0, a} + {1'b0, b} + {32'b0, c};
    v = (a[31] == b[31]) && (t[31] != a[31]);
    return {t[31:0], t[32], v};
  endfunction

  // Behavioural adder top: LAT register stages from pads to outputs. It is
  // deliberately not reset so stale results still emerge after a reset.
  logic [33:0] addPipe [LAT];

  always @(posedge clk) begin
    addPipe[0] <= addModel(a_pad, b_pad, carry_in_pad);
    for (int i = 1; i < LAT; i++) begin
      addPipe[i] <= addPipe[i-1];
    end
  end

  assign sum_pad       = addPipe[LAT-1][33:2];
  assign carry_out_pad = addPipe[LAT-1][1];
  assign overflow_pad  = addPipe[LAT-1][0];

  task automatic checkOutput(input string name, input logic [63:0] obs,
                             input logic [63:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every popped response must match the oldest expected.
  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("rsp_word", {26'b0, rsp_sum, rsp_cout, rsp_ovf, rsp_tag},
                    {26'b0, monE});
        rspCount++;
      end
    end
  end

  // Offers one request starting at posedge+1 and waits (bounded) for it to
  // be accepted; the expected result is queued at the acceptance point.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic [TW-1:0] tag,
                               input logic [31:0] es, input logic ec,
                               input logic eo, output int waits);
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
    req_tag   = tag;
    req_valid = 1'b1;
    waits     = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    if (req_ready !== 1'b1) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
    end else begin
      expQ.push_back(exp_t'({es, ec, eo, tag}));
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic sendOp(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [TW-1:0] tag,
                        output int waits);
    logic [33:0] r;
    r = addModel(a, b, cin);
    applyStimulus(a, b, cin, tag, r[33:2], r[1], r[0], waits);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || rsp_valid === 1'b1) && n < 100) begin
      tick();
      n++;
    end
    checkOutput(name, 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int ws [8];
    int base;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = 1'b0;
    req_tag   = '0;
    rsp_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset values
    checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_err", 64'(err), 64'd0);
    checkOutput("reset_pads", {31'b0, a_pad, carry_in_pad}, 64'd0);
    checkOutput("reset_b_pad", 64'(b_pad), 64'd0);

    // Single op and its latency: rsp_valid low for 4 negedges, then high
    rsp_ready = 1'b1;
    applyStimulus(32'h1, 32'h2, 1'b0, 4'd5, 32'h3, 1'b0, 1'b0, w);
    checkOutput("single_wait", 64'(w), 64'd0);
    checkOutput("single_busy", 64'(busy), 64'd1);
    checkOutput("single_a_pad", 64'(a_pad), 64'h1);
    checkOutput("single_b_pad", 64'(b_pad), 64'h2);
    repeat (4) begin
      @(negedge clk);
      checkOutput("single_early_rsp", 64'(rsp_valid), 64'd0);
    end
    @(negedge clk);
    checkOutput("single_rsp_valid", 64'(rsp_valid), 64'd1);
    tick();
    checkOutput("single_idle_busy", 64'(busy), 64'd0);
    checkOutput("single_idle_rsp", 64'(rsp_valid), 64'd0);
    checkOutput("single_count", 64'(rspCount), 64'd1);

    // Arithmetic corners, expected values written out directly
    applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 4'd1, 32'h0, 1'b1, 1'b0, w);
    applyStimulus(32'h7FFF_FFFF, 32'h1, 1'b0, 4'd2, 32'h8000_0000, 1'b0, 1'b1, w);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 4'd3, 32'h0, 1'b1, 1'b1, w);
    applyStimulus(32'h0, 32'h0, 1'b1, 4'd4, 32'h1, 1'b0, 1'b0, w);
    waitDrain("corners_drain");
    checkOutput("corners_count", 64'(rspCount), 64'd5);

    // Streaming: 8 back-to-back, four credits then a stall
    base = rspCount;
    for (int i = 0; i < 8; i++) begin
      sendOp($urandom, $urandom, 1'($urandom_range(0, 1)), TW'(i), ws[i]);
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput("stream_no_stall", 64'(ws[i]), 64'd0);
    end
    checkOutput("stream_stall5", 64'(ws[4] != 0), 64'd1);
    waitDrain("stream_drain");
    checkOutput("stream_count", 64'(rspCount - base), 64'd8);
    checkOutput("stream_err", 64'(err), 64'd0);

    // Backpressure: 4 accepted, 5th held off, pads keep 4th operands
    base = rspCount;
    rsp_ready = 1'b0;
    sendOp(32'h1111_0000, 32'h1, 1'b0, 4'd1, w);
    sendOp(32'h2222_0000, 32'h2, 1'b0, 4'd2, w);
    sendOp(32'h3333_0000, 32'h3, 1'b1, 4'd3, w);
    sendOp(32'h4444_4444, 32'h1111, 1'b1, 4'd4, w);
    checkOutput("bp_4th_wait", 64'(w), 64'd0);
    req_a     = 32'h5555_0000;
    req_b     = 32'h5;
    req_cin   = 1'b0;
    req_tag   = 4'd5;
    req_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_ready_low", 64'(req_ready), 64'd0);
    end
    checkOutput("bp_a_pad_hold", 64'(a_pad), 64'h4444_4444);
    checkOutput("bp_b_pad_hold", {31'b0, b_pad, carry_in_pad}, {31'b0, 32'h1111, 1'b1});
    checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    sendOp(32'h5555_0000, 32'h5, 1'b0, 4'd5, w);
    sendOp(32'h6666_0000, 32'h6, 1'b0, 4'd6, w);
    waitDrain("bp_drain");
    checkOutput("bp_count", 64'(rspCount - base), 64'd6);

    // Simultaneous events
    base = rspCount;
    rsp_ready = 1'b0;
    sendOp(32'h10, 32'h8, 1'b0, 4'd8, w);
    sendOp(32'h10, 32'h9, 1'b0, 4'd9, w);
    sendOp(32'h10, 32'hA, 1'b0, 4'd10, w);
    sendOp(32'h10, 32'hB, 1'b0, 4'd11, w);
    repeat (6) tick();
    req_a     = 32'h20;
    req_b     = 32'hC;
    req_cin   = 1'b0;
    req_tag   = 4'd12;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("sim_ready_at_full", 64'(req_ready), 64'd0);
    checkOutput("sim_rsp_at_full", 64'(rsp_valid), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("sim_ready_after_pop", 64'(req_ready), 64'd1);
    if (req_ready === 1'b1) begin
      expQ.push_back(exp_t'({32'h2C, 1'b0, 1'b0, 4'd12}));
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("sim_ready_used3", 64'(req_ready), 64'd1);
    tick();
    sendOp(32'h20, 32'hD, 1'b0, 4'd13, w);
    checkOutput("sim_used3_accept_wait", 64'(w), 64'd0);
    req_a     = 32'h20;
    req_b     = 32'hE;
    req_tag   = 4'd14;
    req_valid = 1'b1;
    @(negedge clk);
    checkOutput("sim_ready_used4", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    sendOp(32'h20, 32'hE, 1'b0, 4'd14, w);
    waitDrain("sim_drain");
    checkOutput("sim_count", 64'(rspCount - base), 64'd7);

    // Reset with 1 buffered and 3 in flight
    rsp_ready = 1'b0;
    sendOp(32'hAAAA_0000, 32'h1, 1'b0, 4'd1, w);
    repeat (5) tick();
    sendOp(32'hBBBB_0000, 32'h2, 1'b0, 4'd2, w);
    sendOp(32'hCCCC_0000, 32'h3, 1'b0, 4'd3, w);
    sendOp(32'hDDDD_0000, 32'h4, 1'b0, 4'd4, w);
    checkOutput("rst_buffered", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expQ.delete();
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_pads", {31'b0, a_pad, carry_in_pad}, 64'd0);
    checkOutput("rst_b_pad", 64'(b_pad), 64'd0);
    rsp_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    checkOutput("final_err", 64'(err), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
